// File: rtl/cla_nibble_seq_adder_if.sv
// Handshake/data bundle for cla_nibble_seq_adder.
// master: operand producer / result consumer side; slave: the adder itself.
// Optional macro CLA_SEQ_SUB_EN adds the 'sub' request bit.
interface cla_nibble_seq_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
`ifdef CLA_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef CLA_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder sharing one 4-bit carry-lookahead unit across
// all operand nibbles, LSB nibble first, with the carry registered between
// nibbles. One operation in flight; valid/ready on both sides.
// Optional macro CLA_SEQ_SUB_EN: adds 'sub' (a - b, cout=1 means no borrow).
module cla_nibble_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_nibble_seq_adder_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand, result and sequencing registers
    logic [NIB-1:0][3:0] a_r;
    logic [NIB-1:0][3:0] b_r;
    logic [NIB-1:0][3:0] sum_r;
    logic [IDXW-1:0]     idx;
    logic                carry_r;
    logic                cout_r;

    // FSM decode
    logic accept;
    logic step;
    logic last_step;
    logic in_ready_c;
    logic out_valid_c;
    logic busy_c;

    // Shared lookahead unit
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_g;
    logic [3:0] nib_p;
    logic [3:0] nib_c;
    logic [3:0] nib_sum;

    // Subtract request; constant zero in the add-only build
    logic sub_sel;
`ifdef CLA_SEQ_SUB_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        step        = 1'b0;
        last_step   = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (idx == LAST) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // 4-bit carry-lookahead on the nibble selected by idx
    always_comb begin
        nib_a    = a_r[idx];
        nib_b    = b_r[idx];
        nib_g    = nib_a & nib_b;
        nib_p    = nib_a ^ nib_b;
        nib_c[0] = nib_g[0]
                 | (nib_p[0] & carry_r);
        nib_c[1] = nib_g[1]
                 | (nib_p[1] & nib_g[0])
                 | (nib_p[1] & nib_p[0] & carry_r);
        nib_c[2] = nib_g[2]
                 | (nib_p[2] & nib_g[1])
                 | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & carry_r);
        nib_c[3] = nib_g[3]
                 | (nib_p[3] & nib_g[2])
                 | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_r);
        nib_sum  = nib_p ^ {nib_c[2:0], carry_r};
    end

    // Operand capture at accept, one nibble per cycle while running
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
        end else if (accept) begin
            a_r     <= bus.a;
            // subtract as a + ~b + 1: invert b once here and seed the carry
            b_r     <= sub_sel ? ~bus.b : bus.b;
            idx     <= '0;
            carry_r <= sub_sel ? 1'b1 : bus.cin;
        end else if (step) begin
            sum_r[idx] <= nib_sum;
            carry_r    <= nib_c[3];
            if (last_step) begin
                cout_r <= nib_c[3];
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench for cla_nibble_seq_adder (WIDTH=16).
// Table-driven vectors plus hand sequences; a negedge scoreboard checks
// every output handshake against an arithmetic model.
module tb_cla_nibble_seq_adder;
    localparam int unsigned W = 16;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   pops;
    logic [W:0] exp_q[$];

    cla_nibble_seq_adder_if #(.WIDTH(W)) bus();

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake
    always @(negedge clk) begin
        logic [W:0] e;
        logic       s;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 64'(bus.sum), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum", 64'(bus.sum), 64'(e[W-1:0]));
                    check("sb_cout", 64'(bus.cout), 64'(e[W]));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
`ifdef CLA_SEQ_SUB_EN
                s = bus.sub;
`else
                s = 1'b0;
`endif
                exp_q.push_back(model(bus.a, bus.b, bus.cin, s));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and return just after its accepting edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    // Count edges from the accept until out_valid rises (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vt[11];
    int   acc[3];
    int   lat;
    int   exp_pops;
    logic [W-1:0] held_sum;
    logic         held_cout;

    initial begin
        vt[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vt[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vt[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[3]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vt[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vt[7]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[9]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vt[10] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};

        tests = 0; fails = 0; cyc = 0; pops = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        bus.sub = 1'b0;
`endif
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        rst = 1'b0;
        tick();

        // Table vectors with latency check
        for (int i = 0; i < 11; i++) begin
            start_op(vt[i].a, vt[i].b, vt[i].cin);
            check($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
            wait_out(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("v%0d_sum", i), 64'(bus.sum), 64'(vt[i].s));
            check($sformatf("v%0d_cout", i), 64'(bus.cout), 64'(vt[i].c));
            tick();
            check($sformatf("v%0d_released", i), 64'(bus.out_valid), 64'd0);
        end

        // Backpressure: result held, no new accept
        bus.out_ready = 1'b0;
        start_op(16'h1357, 16'h2468, 1'b1);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'd4);
        check("bp_sum", 64'(bus.sum), 64'h37C0);
        check("bp_cout", 64'(bus.cout), 64'd0);
        held_sum  = bus.sum;
        held_cout = bus.cout;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_sum_stable", 64'(bus.sum), 64'(held_sum));
            check("bp_cout_stable", 64'(bus.cout), 64'(held_cout));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid_high", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset during the second RUN cycle aborts the operation
        start_op(16'h1111, 16'h2222, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_sum", 64'(bus.sum), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        wait_out(lat);
        check("post_abort_latency", 64'(lat), 64'd4);
        check("post_abort_sum", 64'(bus.sum), 64'h1000);
        check("post_abort_cout", 64'(bus.cout), 64'd0);
        tick();

        // Back-to-back with in_valid and out_ready held high
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                tick();
                n++;
            end
            check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            acc[k] = cyc;
            bus.a = 16'h1000 * 16'(k + 2);
            bus.b = 16'hF00F;
            bus.cin = 1'(k);
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("b2b_last_latency", 64'(lat), 64'd4);
        tick();
        check("b2b_spacing_0_1", 64'(acc[1] - acc[0]), 64'd6);
        check("b2b_spacing_1_2", 64'(acc[2] - acc[1]), 64'd6);
        exp_pops = 11 + 1 + 1 + 3;

`ifdef CLA_SEQ_SUB_EN
        bus.sub = 1'b1;
        start_op(16'h0005, 16'h0007, 1'b0);
        wait_out(lat);
        check("sub_lt_sum", 64'(bus.sum), 64'hFFFE);
        check("sub_lt_cout", 64'(bus.cout), 64'd0);
        tick();
        bus.sub = 1'b1;
        start_op(16'h0007, 16'h0005, 1'b1);
        wait_out(lat);
        check("sub_ge_sum", 64'(bus.sum), 64'h0002);
        check("sub_ge_cout", 64'(bus.cout), 64'd1);
        tick();
        bus.sub = 1'b0;
        exp_pops = exp_pops + 2;
`endif

        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("sb_pop_count", 64'(pops), 64'(exp_pops));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-lookahead unit (CLL) across all nibbles of the operands, least-significant nibble first.
- Intended for area-constrained paths where a full-width CLA/CRA is not justified.
- Valid/ready handshake on input and output; one operation in flight at a time.
- Carry is registered between nibbles; each nibble uses CLL lookahead internally.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4; elaboration error otherwise.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/cin valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to nibble 0.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, registered.
- cout  out  1  carry out of MSB nibble, registered.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry reg=0.
- A reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b, cin into internal regs; set idx=0, carry_r=cin; go to RUN. Input values outside the accept edge are ignored.
- RUN: in_ready=0, busy=1. Each cycle, drive CLL with A=a_r[4*idx+:4], B=b_r[4*idx+:4], cIn=carry_r.
  - Nibble sum bit i = a^b^c_i, where c_0=carry_r and c_i=carry[i-1] for i>0.
  - Write the nibble to sum_r[4*idx+:4]; carry_r <= carry[3]; idx <= idx+1.
  - After the step with idx==NIB-1: cout <= carry[3], go to DONE.
- DONE: out_valid=1. sum and cout are held stable until out_valid&&out_ready. On that handshake go to IDLE with out_valid=0.
- No same-cycle re-accept: in_ready is low in DONE, so the earliest next accept is the cycle after the output handshake.
- Latency: out_valid rises NIB clock edges after the accepting edge (4 for WIDTH=16).
- Throughput: one op per NIB+2 cycles when out_ready is held high.
- sum bits are modulo 2^WIDTH; cout is the true carry out.
- Bits of sum for nibbles not yet processed may change during RUN. Consumers sample only when out_valid=1.
- idx width is clog2(NIB), min 1. idx never wraps inside an operation.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched at accept.
  - When sub=1, b_r is stored inverted and the initial carry_r=1, so the result is a-b mod 2^WIDTH. cin is ignored, and cout=1 means no borrow (a>=b, unsigned).
  - When sub=0, behaviour is identical to the non-macro build.
- Undefined: no sub port; the block is add-only exactly as described above.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid exactly 4 edges after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (ripple across all nibble boundaries). Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; check sum/cout stable, in_ready=0, and a new in_valid is not accepted. Release -> IDLE next edge, in_ready=1.
- Reset: assert rst for 1 cycle during the second RUN cycle -> next cycle out_valid=0, in_ready=1, sum=0, cout=0. A subsequent op 0x0F0F+0x00F1 -> 0x1000, cout=0.
- Back-to-back: 3 ops with in_valid and out_ready held high -> accepts spaced NIB+2=6 cycles apart, results in order.
- With CLA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
